// File: rtl/psum_drain_sched_pkg.sv
// Shared accelerator definitions: drain FSM states, default psum width and
// the index-width helper used by the scheduler and its arbiter.
package psum_drain_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2
  } drain_state_e;

  localparam int unsigned DEFAULT_DATA_WIDTH = 16;

  // A one-column build still needs a 1-bit index port.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/psum_drain_sched_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr_i,
// wrapping, reported as a one-hot grant plus its binary index.
module rr_arbiter
  import psum_drain_sched_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]               req_i,
  input  logic [idx_width(N)-1:0]    ptr_i,
  output logic [N-1:0]               gnt_o,
  output logic [idx_width(N)-1:0]    idx_o,
  output logic                       vld_o
);

  localparam int unsigned IDX_W = idx_width(N);

  always_comb begin
    int c;
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    c     = 0;
    for (int k = 0; k < int'(N); k++) begin
      c = int'(ptr_i) + k;
      if (c >= int'(N)) c = c - int'(N);
      if (!vld_o && req_i[c]) begin
        vld_o    = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/psum_drain_sched.sv
// Drains per-column psum FIFOs round-robin into a single valid/ready stream,
// taking exactly G_WORDS_PER_COL words from each column per layer.
module psum_drain_sched
  import psum_drain_sched_pkg::*;
#(
  parameter int unsigned G_NUM_COLS      = 4,
  parameter int unsigned G_DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int unsigned G_WORDS_PER_COL = 144
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 start_i,
  output logic                                 busy_o,
  output logic                                 done_o,
  input  logic [G_NUM_COLS-1:0]                psum_empty_i,
  input  logic [G_NUM_COLS*G_DATA_WIDTH-1:0]   psum_i,
  output logic [G_NUM_COLS-1:0]                psum_rd_en_o,
  output logic                                 out_vld_o,
  input  logic                                 out_ready_i,
  output logic [G_DATA_WIDTH-1:0]              out_data_o,
  output logic [idx_width(G_NUM_COLS)-1:0]     out_col_o
);

  localparam int unsigned COL_W = idx_width(G_NUM_COLS);
  localparam int unsigned CNT_W = $clog2(G_WORDS_PER_COL + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(G_WORDS_PER_COL);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(G_NUM_COLS - 1);

  drain_state_e            state_q;
  logic [COL_W-1:0]        ptr_q;
  logic [CNT_W-1:0]        cnt_q [G_NUM_COLS];
  logic                    out_vld_q;
  logic [G_DATA_WIDTH-1:0] out_data_q;
  logic [COL_W-1:0]        out_col_q;
  logic                    done_q;

  logic [G_NUM_COLS-1:0]   col_open;
  logic [G_NUM_COLS-1:0]   req;
  logic [G_NUM_COLS-1:0]   gnt;
  logic [COL_W-1:0]        gnt_idx;
  logic                    gnt_vld;
  logic [G_DATA_WIDTH-1:0] gnt_data;
  logic [COL_W-1:0]        ptr_d;
  logic                    slot_free;
  logic                    all_full_d;

  // The output register can take a new word if empty or being emptied now.
  assign slot_free = !out_vld_q || out_ready_i;

  always_comb begin
    for (int c = 0; c < int'(G_NUM_COLS); c++) begin
      col_open[c] = (cnt_q[c] < CNT_MAX);
    end
  end

  assign req = (state_q == ST_DRAIN && slot_free) ? (~psum_empty_i & col_open) : '0;

  rr_arbiter #(
    .N (G_NUM_COLS)
  ) u_rr_arbiter (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .vld_o (gnt_vld)
  );

  always_comb begin
    gnt_data = '0;
    for (int c = 0; c < int'(G_NUM_COLS); c++) begin
      if (gnt[c]) gnt_data = psum_i[c*G_DATA_WIDTH +: G_DATA_WIDTH];
    end
  end

  assign ptr_d = (gnt_idx == COL_LAST) ? '0 : gnt_idx + 1'b1;

  // Look ahead at this cycle's grant so FLUSH starts as the counters fill.
  always_comb begin
    all_full_d = 1'b1;
    for (int c = 0; c < int'(G_NUM_COLS); c++) begin
      if ((cnt_q[c] + CNT_W'(gnt[c])) != CNT_MAX) all_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: the counter array is a handful of flops, not RAM, so it is reset like any register.
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_col_q  <= '0;
      done_q     <= 1'b0;
      for (int c = 0; c < int'(G_NUM_COLS); c++) cnt_q[c] <= '0;
    end else begin
      // NOTE: non-blocking updates keep every register reading pre-edge values.
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q <= ST_DRAIN;
            ptr_q   <= '0;
            for (int c = 0; c < int'(G_NUM_COLS); c++) cnt_q[c] <= '0;
          end
        end
        ST_DRAIN: begin
          // A grant is only issued below CNT_MAX, so counters saturate there.
          if (gnt_vld) ptr_q <= ptr_d;
          for (int c = 0; c < int'(G_NUM_COLS); c++) begin
            if (gnt[c]) cnt_q[c] <= cnt_q[c] + CNT_W'(1);
          end
          if (all_full_d) state_q <= ST_FLUSH;
        end
        ST_FLUSH: begin
          if (slot_free) begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      if (gnt_vld) begin
        out_vld_q  <= 1'b1;
        out_data_q <= gnt_data;
        out_col_q  <= gnt_idx;
      end else if (out_ready_i) begin
        out_vld_q  <= 1'b0;
      end
    end
  end

  assign psum_rd_en_o = gnt;
  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = done_q;
  assign out_vld_o    = out_vld_q;
  assign out_data_o   = out_data_q;
  assign out_col_o    = out_col_q;

endmodule

// File: tb/tb_psum_drain_sched.sv
// Directed + randomized bench for psum_drain_sched against a queue-based
// reference of the round-robin drain rules.
module tb_psum_drain_sched;

  localparam int NC  = 4;
  localparam int DW  = 16;
  localparam int WPC = 3;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              start_i;
  logic              busy_o;
  logic              done_o;
  logic [NC-1:0]     psum_empty_i;
  logic [NC*DW-1:0]  psum_i;
  logic [NC-1:0]     psum_rd_en_o;
  logic              out_vld_o;
  logic              out_ready_i;
  logic [DW-1:0]     out_data_o;
  logic [1:0]        out_col_o;

  psum_drain_sched #(
    .G_NUM_COLS      (NC),
    .G_DATA_WIDTH    (DW),
    .G_WORDS_PER_COL (WPC)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .psum_empty_i (psum_empty_i),
    .psum_i       (psum_i),
    .psum_rd_en_o (psum_rd_en_o),
    .out_vld_o    (out_vld_o),
    .out_ready_i  (out_ready_i),
    .out_data_o   (out_data_o),
    .out_col_o    (out_col_o)
  );

  always #5 clk_i = ~clk_i;

  // Environment FIFOs (popped on the DUT's strobes) and reference state.
  logic [DW-1:0] fifo [NC][$];
  int            m_cnt [NC];
  int            m_ptr;
  bit            m_drain, m_flush, m_vld, m_done;
  logic [DW-1:0] m_data;
  int            m_col;

  int            n_cmp = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            acc_col [$];
  int            acc_cyc [$];
  int            done_cyc = -1;
  logic [NC-1:0] last_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_drain = 0; m_flush = 0; m_vld = 0; m_done = 0;
    m_data  = '0; m_col = 0; m_ptr = 0;
    for (int c = 0; c < NC; c++) m_cnt[c] = 0;
  endtask

  task automatic load(input int c, input int n);
    repeat (n) fifo[c].push_back(DW'($urandom));
  endtask

  // One clock: drive, check against the reference, advance both.
  task automatic cycle(input bit rdy, input bit st);
    int            g;
    int            c;
    bit            free;
    bit            full;
    logic [NC-1:0] exp_rd;
    logic [DW-1:0] gdata;
    out_ready_i = rdy;
    start_i     = st;
    for (int k = 0; k < NC; k++) begin
      psum_empty_i[k]       = (fifo[k].size() == 0);
      psum_i[k*DW +: DW]    = (fifo[k].size() != 0) ? fifo[k][0] : '0;
    end
    #1;
    free  = !m_vld || rdy;
    g     = -1;
    gdata = '0;
    if (m_drain && free) begin
      for (int k = 0; k < NC; k++) begin
        c = (m_ptr + k) % NC;
        if (g < 0 && fifo[c].size() > 0 && m_cnt[c] < WPC) g = c;
      end
    end
    exp_rd = (g >= 0) ? NC'(1 << g) : '0;
    if (g >= 0) gdata = fifo[g][0];
    check("rd_en", 32'(psum_rd_en_o), 32'(exp_rd));
    check("out_vld", 32'(out_vld_o), 32'(m_vld));
    if (m_vld) begin
      check("out_data", 32'(out_data_o), 32'(m_data));
      check("out_col", 32'(out_col_o), 32'(m_col));
    end
    check("done", 32'(done_o), 32'(m_done));
    check("busy", 32'(busy_o), 32'(m_drain || m_flush));
    if (out_vld_o === 1'b1 && rdy) begin
      acc_col.push_back(int'(out_col_o));
      acc_cyc.push_back(cyc);
    end
    if (done_o === 1'b1) done_cyc = cyc;
    last_rd = psum_rd_en_o;
    @(posedge clk_i);
    for (int k = 0; k < NC; k++) begin
      if (last_rd[k] === 1'b1 && fifo[k].size() > 0) void'(fifo[k].pop_front());
    end
    m_done = 0;
    if (g >= 0) begin
      m_vld = 1; m_data = gdata; m_col = g;
      m_cnt[g]++;
      m_ptr = (g + 1) % NC;
    end else if (rdy) begin
      m_vld = 0;
    end
    if (m_drain) begin
      full = 1;
      for (int k = 0; k < NC; k++) if (m_cnt[k] != WPC) full = 0;
      if (full) begin m_drain = 0; m_flush = 1; end
    end else if (m_flush) begin
      if (free) begin m_flush = 0; m_done = 1; end
    end else if (st) begin
      m_drain = 1; m_ptr = 0;
      for (int k = 0; k < NC; k++) m_cnt[k] = 0;
    end
    cyc++;
    @(negedge clk_i);
  endtask

  task automatic run_to_done(input int budget, input bit rnd_rdy, input bit poke_start);
    int n;
    n = 0;
    while ((m_drain || m_flush) && n < budget) begin
      cycle(rnd_rdy ? ($urandom_range(3) != 0) : 1'b1,
            poke_start ? ($urandom_range(3) == 0) : 1'b0);
      n++;
    end
    check("drain_timeout", 32'(n < budget), 32'd1);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
  endtask

  initial begin
    logic [DW-1:0] hold_data;
    logic [1:0]    hold_col;
    int            n;
    rst_ni       = 1'b0;
    start_i      = 1'b0;
    out_ready_i  = 1'b1;
    psum_empty_i = '0;
    psum_i       = '0;
    model_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    check("rst_vld", 32'(out_vld_o), 32'd0);
    check("rst_data", 32'(out_data_o), 32'd0);
    check("rst_col", 32'(out_col_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_rd_en", 32'(psum_rd_en_o), 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Basic: 3 words per column, always ready.
    for (int c = 0; c < NC; c++) load(c, WPC);
    acc_col.delete(); acc_cyc.delete();
    cycle(1'b1, 1'b1);
    run_to_done(100, 1'b0, 1'b0);
    check("basic_count", 32'(acc_col.size()), 32'd12);
    for (int i = 0; i < acc_col.size() && i < 12; i++) begin
      check("basic_col", 32'(acc_col[i]), 32'(i % NC));
      check("basic_consec", 32'(acc_cyc[i]), 32'(acc_cyc[0] + i));
    end
    if (acc_cyc.size() > 0) check("basic_done_lat", 32'(done_cyc), 32'(acc_cyc[acc_cyc.size()-1] + 1));

    // Backpressure: hold output for 5 cycles.
    for (int c = 0; c < NC; c++) load(c, WPC);
    cycle(1'b1, 1'b1);
    repeat (3) cycle(1'b1, 1'b0);
    hold_data = out_data_o;
    hold_col  = out_col_o;
    repeat (5) begin
      cycle(1'b0, 1'b0);
      check("bp_rd_en", 32'(last_rd), 32'd0);
      check("bp_data", 32'(out_data_o), 32'(hold_data));
      check("bp_col", 32'(out_col_o), 32'(hold_col));
    end
    run_to_done(200, 1'b1, 1'b0);

    // Sparse: only column 2, then wrap from pointer 3.
    load(2, 2);
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b0);
    check("sparse_first", 32'(last_rd), 32'b0100);
    cycle(1'b1, 1'b0);
    check("sparse_wrap", 32'(last_rd), 32'b0100);
    load(0, 1);
    load(3, 1);
    cycle(1'b1, 1'b0);
    check("sparse_ptr3", 32'(last_rd), 32'b1000);
    load(0, 2); load(1, 3); load(2, 1); load(3, 2);
    run_to_done(200, 1'b1, 1'b0);

    // Over-full column 1: two words must stay behind.
    load(0, WPC); load(1, 5); load(2, WPC); load(3, WPC);
    cycle(1'b1, 1'b1);
    done_cyc = -1;
    run_to_done(200, 1'b1, 1'b0);
    check("overfull_left1", 32'(fifo[1].size()), 32'd2);
    check("overfull_left0", 32'(fifo[0].size()), 32'd0);
    check("overfull_done", 32'(done_cyc >= 0), 32'd1);
    fifo[1].delete();

    // Reset after 6 accepted words, then a clean restart.
    for (int c = 0; c < NC; c++) load(c, WPC);
    acc_col.delete(); acc_cyc.delete();
    cycle(1'b1, 1'b1);
    n = 0;
    while (acc_col.size() < 6 && n < 50) begin
      cycle(1'b1, 1'b0);
      n++;
    end
    check("mid_accepted", 32'(acc_col.size()), 32'd6);
    #2;
    rst_ni = 1'b0;
    #1;
    check("mid_rst_vld", 32'(out_vld_o), 32'd0);
    check("mid_rst_busy", 32'(busy_o), 32'd0);
    check("mid_rst_rd_en", 32'(psum_rd_en_o), 32'd0);
    check("mid_rst_done", 32'(done_o), 32'd0);
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int c = 0; c < NC; c++) fifo[c].delete();
    @(negedge clk_i);
    for (int c = 0; c < NC; c++) load(c, WPC);
    acc_col.delete(); acc_cyc.delete();
    cycle(1'b1, 1'b1);
    // Stray start pulses while draining must be ignored.
    run_to_done(300, 1'b1, 1'b1);
    check("restart_words", 32'(acc_col.size()), 32'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/psum_drain_sched.md
PSUM_DRAIN_SCHED -- requirements
Module: psum_drain_sched

Interface
REQ-001 SHALL have parameter G_NUM_COLS, default 4, number of psum FIFOs drained (one per array column).
REQ-002 SHALL have parameter G_DATA_WIDTH, default 16, psum word width.
REQ-003 SHALL have parameter G_WORDS_PER_COL, default 144, psum words expected per column per layer.
REQ-004 SHALL have ports: clk_i  in  1  clock; rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: start_i  in  1  begin drain; busy_o  out  1  high outside IDLE; done_o  out  1  one-cycle completion pulse.
REQ-006 SHALL have ports: psum_empty_i  in  G_NUM_COLS  FWFT FIFO empty flags; psum_i  in  G_NUM_COLS x G_DATA_WIDTH  FIFO heads; psum_rd_en_o  out  G_NUM_COLS  pop strobes.
REQ-007 SHALL have ports: out_vld_o  out  1; out_ready_i  in  1; out_data_o  out  G_DATA_WIDTH; out_col_o  out  clog2(G_NUM_COLS)  source column index.

Function
REQ-008 SHALL implement states IDLE, DRAIN, FLUSH.
REQ-009 IDLE: start_i=1 -> DRAIN, clears all per-column word counters and sets round-robin pointer to 0. start_i in any other state is ignored.
REQ-010 A column SHALL be eligible when psum_empty_i[c]=0 and its counter < G_WORDS_PER_COL.
REQ-011 In DRAIN, the eligible column SHALL be granted only when the output slot can accept: out_vld_o=0 or (out_vld_o=1 and out_ready_i=1).
REQ-012 Grant SHALL be the first eligible column at or after the pointer, wrapping modulo G_NUM_COLS; at most one grant per cycle.
REQ-013 On grant c: psum_rd_en_o[c]=1 combinationally for that cycle only; psum_i[c] and c are registered to out_data_o/out_col_o with out_vld_o=1 next cycle; counter[c] increments; pointer becomes (c+1) mod G_NUM_COLS.
REQ-014 psum_rd_en_o SHALL never assert for an empty FIFO, for a finished column, or outside DRAIN.
REQ-015 out_vld_o SHALL, once high, hold out_data_o and out_col_o stable until out_ready_i=1; an accepted slot with no new grant clears out_vld_o.
REQ-016 Throughput: one word per cycle sustained when out_ready_i=1 and an eligible column exists; latency FIFO pop -> out_vld_o is 1 cycle.
REQ-017 When all counters equal G_WORDS_PER_COL, DRAIN -> FLUSH.
REQ-018 FLUSH: when out_vld_o=0, or out_vld_o=1 and out_ready_i=1 in that cycle, SHALL pulse done_o for one cycle and go to IDLE.
REQ-019 Words remaining in a finished column's FIFO SHALL be left unread.
REQ-020 Counters SHALL be clog2(G_WORDS_PER_COL+1) bits wide and saturate at G_WORDS_PER_COL.

Reset
REQ-021 rst_ni=0 SHALL asynchronously force IDLE, pointer 0, counters 0, out_vld_o=0, out_data_o=0, out_col_o=0, done_o=0, busy_o=0; psum_rd_en_o SHALL be 0 while in reset.
REQ-022 Reset asserted mid-DRAIN SHALL abort the transfer with no done_o pulse; the in-flight output word is discarded.

Structure
REQ-023 State enum (IDLE, DRAIN, FLUSH) and the default G_DATA_WIDTH constant SHALL reside in the shared accelerator package.
REQ-024 Round-robin selection SHALL be one sub-module, rr_arbiter (request vector, pointer in; one-hot grant and index out; combinational).

Verification
REQ-025 Basic: G_WORDS_PER_COL=3, all four FIFOs preloaded with 3 words, out_ready_i=1 -> output columns 0,1,2,3,0,1,2,3,0,1,2,3 on 12 consecutive cycles; done_o one cycle after the last word is accepted.
REQ-026 Backpressure: out_ready_i low for 5 cycles with out_vld_o=1 -> out_data_o and out_col_o unchanged, psum_rd_en_o all 0 throughout.
REQ-027 Sparse: only column 2 non-empty, pointer at 3 -> grant column 2 (wrap), then pointer becomes 3.
REQ-028 Over-full FIFO: column 1 holds 5 words, G_WORDS_PER_COL=3 -> exactly 3 pops from column 1; 2 words remain; done_o still asserts.
REQ-029 Reset mid-drain: rst_ni low after 6 words -> out_vld_o=0 and busy_o=0 immediately; no done_o; a new start_i after reset restarts all counters at 0.
REQ-030 start_i pulsed during DRAIN -> no effect on counters, pointer, or done_o timing.
